mem_responder: RTL and testbench

Responder end of the single-outstanding memory request interface: it accepts level-held read/write requests on the `mem_*` bus, services them from an internal word array after a fixed latency, and raises `mem_response` to complete each transaction. It sits on the memory side of the bus and serves as the backing store and timing model behind the CPU-side data/instruction memory initiators.

---
 rtl/mem_if_pkg.sv | 13 +
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and widths for the single-outstanding memory request interface.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_resp_state_t;

  localparam int MEM_BUS_W = 32;
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, write-first; one-cycle registered read.
// No backpressure: one read or write operation per enabled cycle.
module mem_array #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-latency service of level-held requests, response held until enables drop.
// Latency LATENCY cycles capture-to-response; the held request itself is the backpressure, no re-trigger.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_BUS_W-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [MEM_BUS_W-1:0] mem_write_val,
  output logic [MEM_BUS_W-1:0] mem_read_val,
  output logic                 mem_response,
  output logic                 mem_addr_err
);

  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  mem_resp_state_t       state, state_nxt;
  logic [LAT_CNT_W-1:0]  cnt;
  logic [MEM_BUS_W-1:0]  addr_q;
  logic [MEM_WIDTH-1:0]  wdata_q;
  logic [MEM_WIDTH-1:0]  ram_rdata;
  logic                  rd_q, wr_q;
  logic                  err_q, rd_zero_q;
  logic                  commit, in_range;
  logic                  ram_we, ram_re;

  assign in_range = (addr_q < MEM_BUS_W'(MEM_SIZE));
  assign commit   = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_read_en || mem_write_en) state_nxt = BUSY;
      BUSY: if (cnt == '0) state_nxt = RESP;
      RESP: if (!mem_read_en && !mem_write_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_response = (state == RESP);
    mem_addr_err = (state == RESP) && err_q;
    ram_we       = commit && wr_q && in_range && !reset;
    ram_re       = commit && rd_q && in_range && !reset;
  end

  // Capture only in IDLE so bus changes during a transaction are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      if (state == IDLE && (mem_read_en || mem_write_en)) begin
        cnt     <= LAT_CNT_W'(LATENCY - 1);
        addr_q  <= mem_addr;
        wdata_q <= mem_write_val[MEM_WIDTH-1:0];
        rd_q    <= mem_read_en;
        wr_q    <= mem_write_en;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        err_q <= !in_range;
        if (rd_q) rd_zero_q <= !in_range;
      end
    end
  end

  mem_array #(
    .MEM_WIDTH(MEM_WIDTH),
    .MEM_SIZE (MEM_SIZE),
    .AW       (AW)
  ) u_mem_array (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q[AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Out-of-range reads mask the RAM register so it keeps its last real value.
  always_comb begin
    mem_read_val = '0;
    if (!rd_zero_q) mem_read_val[MEM_WIDTH-1:0] = ram_rdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expectations, a monitor checks each response edge.
module tb_mem_responder;

  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;
  logic        mem_response;
  logic        mem_addr_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  typedef struct {
    logic [31:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mem_responder #(
    .MEM_WIDTH(32),
    .MEM_SIZE (256),
    .LATENCY  (LATENCY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_write_val(mem_write_val),
    .mem_read_val (mem_read_val),
    .mem_response (mem_response),
    .mem_addr_err (mem_addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  // Monitor: every rising edge of mem_response must match the oldest expectation.
  initial begin : monitor
    logic resp_prev;
    exp_t e;
    resp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_response === 1'b1 && resp_prev === 1'b0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response @cycle %0d", cycle);
        end else begin
          e = sb.pop_front();
          check("read_val", mem_read_val, e.val);
          check("addr_err", {31'b0, mem_addr_err}, {31'b0, e.err});
          check("resp_cycle", cycle, e.cyc);
        end
      end
      resp_prev = mem_response;
    end
  end

  // Issue one request, scramble the bus while busy, hold the enables 'hold' cycles past the response.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_val, input bit exp_err, input int hold);
    int t;
    @(negedge clk);
    mem_read_en   = rd;
    mem_write_en  = wr;
    mem_addr      = addr;
    mem_write_val = data;
    sb.push_back('{exp_val, exp_err, cycle + 1 + LATENCY});
    @(negedge clk);
    mem_addr      = ~addr;
    mem_write_val = ~data;
    t = 0;
    while (mem_response !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (mem_response !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL response_timeout addr 0x%08h: got no response, expected one within 20 cycles", addr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_response", {31'b0, mem_response}, 32'd1);
    end
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    @(negedge clk);
    check("response_fall", {31'b0, mem_response}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_write_val = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_response", {31'b0, mem_response}, 32'd0);
      check("rst_read_val", mem_read_val, 32'd0);
      check("rst_addr_err", {31'b0, mem_addr_err}, 32'd0);
      @(negedge clk);
    end

    txn(1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 32'h0,        1'b0, 0);
    txn(1'b1, 1'b0, 32'd5,   32'h0,        32'hDEADBEEF, 1'b0, 6);
    txn(1'b0, 1'b1, 32'd44,  32'hCAFE0044, 32'hDEADBEEF, 1'b0, 0);
    txn(1'b1, 1'b0, 32'd256, 32'h0,        32'h0,        1'b1, 0);
    txn(1'b0, 1'b1, 32'd300, 32'h1234,     32'h0,        1'b1, 0);
    txn(1'b1, 1'b0, 32'd44,  32'h0,        32'hCAFE0044, 1'b0, 0);
    txn(1'b1, 1'b1, 32'd7,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0);
    txn(1'b1, 1'b0, 32'd7,   32'h0,        32'hA5A5A5A5, 1'b0, 0);
    txn(1'b0, 1'b1, 32'd3,   32'h11,       32'hA5A5A5A5, 1'b0, 0);

    // Write aborted by reset two cycles after capture: no response, no commit.
    @(negedge clk);
    mem_write_en  = 1'b1;
    mem_addr      = 32'd3;
    mem_write_val = 32'h55;
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b1;
    mem_write_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      check("abort_no_response", {31'b0, mem_response}, 32'd0);
      @(negedge clk);
    end
    check("abort_read_val_cleared", mem_read_val, 32'd0);

    txn(1'b1, 1'b0, 32'd3, 32'h0, 32'h11, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
